// File: rtl/core_bus_pkg.sv
// Shared definitions for the core-side Wishbone arbiter: FSM state encoding,
// one-hot grant values and the fixed byte select for instruction fetches.
package core_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } arb_state_t;

   // grant_o is one-hot {data, instr}
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;

   // Instruction fetches are always full 32-bit words
   localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts busy cycles without a slave response and flags the
// cycle on which a transfer must be terminated with a forced error.
// TIMEOUT = 0 disables the watchdog (expired never asserts).
module wb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;

   // Saturating busy-cycle counter; clear takes priority over count
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (count && (cnt_q != MAX_CNT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Expiry is only meaningful on a counting cycle, so a slave response wins
   always_comb begin
      expired = (TIMEOUT != 0) && count && (cnt_q == LAST_CNT);
   end

endmodule

// File: rtl/core_wb_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone bus between the core's
// instruction-fetch and data masters. The grant is held for the whole
// transfer; responses are routed only to the owner, and a watchdog forces
// err on transfers the slave never answers.
module core_wb_arbiter
   import core_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          DATA_FIRST = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // instruction master
   input  logic        iwb_cyc_i,
   input  logic        iwb_stb_i,
   input  logic [31:0] iwb_addr_i,
   output logic [31:0] iwb_dat_o,
   output logic        iwb_ack_o,
   output logic        iwb_err_o,
   // data master
   input  logic        dwb_cyc_i,
   input  logic        dwb_stb_i,
   input  logic        dwb_we_i,
   input  logic [3:0]  dwb_sel_i,
   input  logic [31:0] dwb_addr_i,
   input  logic [31:0] dwb_dat_i,
   output logic [31:0] dwb_dat_o,
   output logic        dwb_ack_o,
   output logic        dwb_err_o,
   // shared bus
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic [1:0]  grant_o
);

   arb_state_t state_q;
   logic [1:0] grant_q;
   logic       last_d_q;   // 1: data master owned the bus last

   logic i_req, d_req;
   logic busy, owner_cyc, resp;
   logic wd_clear, wd_count, wd_expired;

   // Request decode and watchdog control
   always_comb begin
      i_req     = iwb_cyc_i & iwb_stb_i;
      d_req     = dwb_cyc_i & dwb_stb_i;
      busy      = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
      owner_cyc = ((state_q == ST_BUSY_I) & iwb_cyc_i) |
                  ((state_q == ST_BUSY_D) & dwb_cyc_i);
      resp      = wbm_ack_i | wbm_err_i;
      wd_count  = busy & owner_cyc & ~resp;
      wd_clear  = ~busy | ~owner_cyc | resp | wd_expired;
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (wd_clear),
      .count   (wd_count),
      .expired (wd_expired)
   );

   // Arbitration FSM with registered grant and round-robin history
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= GNT_NONE;
         last_d_q <= !DATA_FIRST;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_req && d_req) begin
                  if (last_d_q) begin
                     state_q <= ST_BUSY_I;
                     grant_q <= GNT_I;
                  end else begin
                     state_q <= ST_BUSY_D;
                     grant_q <= GNT_D;
                  end
               end else if (d_req) begin
                  state_q <= ST_BUSY_D;
                  grant_q <= GNT_D;
               end else if (i_req) begin
                  state_q <= ST_BUSY_I;
                  grant_q <= GNT_I;
               end
            end
            ST_BUSY_I: begin
               if (!iwb_cyc_i || resp || wd_expired) begin
                  state_q  <= ST_IDLE;
                  grant_q  <= GNT_NONE;
                  last_d_q <= 1'b0;
               end
            end
            ST_BUSY_D: begin
               if (!dwb_cyc_i || resp || wd_expired) begin
                  state_q  <= ST_IDLE;
                  grant_q  <= GNT_NONE;
                  last_d_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= GNT_NONE;
            end
         endcase
      end
   end

   assign grant_o   = grant_q;
   assign iwb_dat_o = wbm_dat_i;
   assign dwb_dat_o = wbm_dat_i;

   // Bus request mux and response routing to the current owner
   always_comb begin
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      wbm_we_o   = 1'b0;
      wbm_sel_o  = '0;
      wbm_addr_o = '0;
      wbm_dat_o  = '0;
      iwb_ack_o  = 1'b0;
      iwb_err_o  = 1'b0;
      dwb_ack_o  = 1'b0;
      dwb_err_o  = 1'b0;
      case (state_q)
         ST_BUSY_I: begin
            wbm_cyc_o  = iwb_cyc_i;
            wbm_stb_o  = iwb_stb_i;
            wbm_sel_o  = SEL_WORD;
            wbm_addr_o = iwb_addr_i;
            iwb_ack_o  = wbm_ack_i;
            iwb_err_o  = wbm_err_i | wd_expired;
         end
         ST_BUSY_D: begin
            wbm_cyc_o  = dwb_cyc_i;
            wbm_stb_o  = dwb_stb_i;
            wbm_we_o   = dwb_we_i;
            wbm_sel_o  = dwb_sel_i;
            wbm_addr_o = dwb_addr_i;
            wbm_dat_o  = dwb_dat_i;
            dwb_ack_o  = wbm_ack_i;
            dwb_err_o  = wbm_err_i | wd_expired;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter (TIMEOUT=4, DATA_FIRST=1): a table of
// arbitration vectors followed by hand-written multi-cycle sequences.
module tb_core_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        iwb_cyc_i, iwb_stb_i;
   logic [31:0] iwb_addr_i, iwb_dat_o;
   logic        iwb_ack_o, iwb_err_o;
   logic        dwb_cyc_i, dwb_stb_i, dwb_we_i;
   logic [3:0]  dwb_sel_i;
   logic [31:0] dwb_addr_i, dwb_dat_i, dwb_dat_o;
   logic        dwb_ack_o, dwb_err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i;
   logic [1:0]  grant_o;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk_i = ~clk_i;

   core_wb_arbiter #(
      .TIMEOUT    (4),
      .DATA_FIRST (1'b1)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .iwb_cyc_i  (iwb_cyc_i),
      .iwb_stb_i  (iwb_stb_i),
      .iwb_addr_i (iwb_addr_i),
      .iwb_dat_o  (iwb_dat_o),
      .iwb_ack_o  (iwb_ack_o),
      .iwb_err_o  (iwb_err_o),
      .dwb_cyc_i  (dwb_cyc_i),
      .dwb_stb_i  (dwb_stb_i),
      .dwb_we_i   (dwb_we_i),
      .dwb_sel_i  (dwb_sel_i),
      .dwb_addr_i (dwb_addr_i),
      .dwb_dat_i  (dwb_dat_i),
      .dwb_dat_o  (dwb_dat_o),
      .dwb_ack_o  (dwb_ack_o),
      .dwb_err_o  (dwb_err_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_addr_o (wbm_addr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_dat_i  (wbm_dat_i),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_err_i  (wbm_err_i),
      .grant_o    (grant_o)
   );

   typedef struct {
      logic       ireq;
      logic       dreq;
      logic       dwe;
      logic [1:0] exp_grant;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drop_all();
      iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
   endtask

   initial begin
      logic exp_d;

      // round-robin history starts as "instr last" because DATA_FIRST=1
      vecs[0] = '{1'b1, 1'b1, 1'b1, 2'b10};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b01};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 2'b10};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b01};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 2'b10};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b10};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b01};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 2'b00};
      vecs[8] = '{1'b0, 1'b1, 1'b1, 2'b10};
      vecs[9] = '{1'b1, 1'b1, 1'b0, 2'b01};

      rst_i      = 1'b0;
      iwb_addr_i = '0;
      dwb_we_i   = 1'b0;
      dwb_sel_i  = 4'b0011;
      dwb_addr_i = 32'h100;
      dwb_dat_i  = '0;
      wbm_dat_i  = '0;
      drop_all();
      step();
      step();
      check("rst_grant", grant_o, 2'b00);
      check("rst_cyc", wbm_cyc_o, 1'b0);
      check("rst_stb", wbm_stb_o, 1'b0);
      rst_i = 1'b1;

      // ---- table-driven arbitration vectors ----
      for (int k = 0; k < 10; k++) begin
         iwb_cyc_i  = vecs[k].ireq;
         iwb_stb_i  = vecs[k].ireq;
         iwb_addr_i = 32'h1000 + k;
         dwb_cyc_i  = vecs[k].dreq;
         dwb_stb_i  = vecs[k].dreq;
         dwb_we_i   = vecs[k].dwe;
         dwb_dat_i  = 32'hA5A50000 + k;
         #1;
         check("idle_grant", grant_o, 2'b00);
         check("idle_stb", wbm_stb_o, 1'b0);
         step();
         check($sformatf("v%0d_grant", k), grant_o, vecs[k].exp_grant);
         check($sformatf("v%0d_stb", k), wbm_stb_o, vecs[k].exp_grant != 2'b00);
         if (vecs[k].exp_grant != 2'b00) begin
            exp_d = (vecs[k].exp_grant == 2'b10);
            check($sformatf("v%0d_addr", k), wbm_addr_o, exp_d ? 32'h100 : 32'h1000 + k);
            check($sformatf("v%0d_sel", k), wbm_sel_o, exp_d ? 4'b0011 : 4'hF);
            check($sformatf("v%0d_we", k), wbm_we_o, exp_d ? vecs[k].dwe : 1'b0);
            check($sformatf("v%0d_wdat", k), wbm_dat_o, exp_d ? 32'hA5A50000 + k : 32'h0);
            wbm_ack_i = 1'b1;
            wbm_dat_i = 32'hC0DE0000 + k;
            #1;
            check($sformatf("v%0d_iack", k), iwb_ack_o, !exp_d);
            check($sformatf("v%0d_dack", k), dwb_ack_o, exp_d);
            check($sformatf("v%0d_idat", k), iwb_dat_o, 32'hC0DE0000 + k);
            check($sformatf("v%0d_ddat", k), dwb_dat_o, 32'hC0DE0000 + k);
         end
         step();
         drop_all();
         check($sformatf("v%0d_end", k), grant_o, 2'b00);
      end

      // ---- single instruction read, one wait state ----
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_addr_i = 32'h2000;
      step();
      check("ird_stb", wbm_stb_o, 1'b1);
      check("ird_ack_early", iwb_ack_o, 1'b0);
      step();
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEADBEEF;
      #1;
      check("ird_ack", iwb_ack_o, 1'b1);
      check("ird_dat", iwb_dat_o, 32'hDEADBEEF);
      check("ird_dack", dwb_ack_o, 1'b0);
      step();
      drop_all();
      check("ird_idle", grant_o, 2'b00);

      // ---- silent slave, watchdog expiry on 4th busy cycle ----
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         check($sformatf("to_noerr%0d", c), dwb_err_o, 1'b0);
      end
      step();
      check("to_err", dwb_err_o, 1'b1);
      check("to_ierr", iwb_err_o, 1'b0);
      check("to_cyc_busy", wbm_cyc_o, 1'b1);
      step();
      check("to_idle_grant", grant_o, 2'b00);
      check("to_idle_cyc", wbm_cyc_o, 1'b0);
      check("to_err_gone", dwb_err_o, 1'b0);
      drop_all();

      // ---- slave ack on the expiry cycle wins ----
      step();
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      repeat (4) step();
      wbm_ack_i = 1'b1;
      #1;
      check("ackx_ack", dwb_ack_o, 1'b1);
      check("ackx_err", dwb_err_o, 1'b0);
      step();
      drop_all();
      check("ackx_idle", grant_o, 2'b00);

      // ---- instruction master abort with a pending data request ----
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      step();
      check("abt_grant", grant_o, 2'b01);
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_addr_i = 32'h300;
      step();
      iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      #1;
      check("abt_cyc", wbm_cyc_o, 1'b0);
      check("abt_iack", iwb_ack_o | iwb_err_o, 1'b0);
      check("abt_dack", dwb_ack_o | dwb_err_o, 1'b0);
      step();
      check("abt_idle", grant_o, 2'b00);
      step();
      check("abt_dgrant", grant_o, 2'b10);
      check("abt_daddr", wbm_addr_o, 32'h300);
      wbm_ack_i = 1'b1;
      #1;
      check("abt_dack2", dwb_ack_o, 1'b1);
      step();
      drop_all();

      // ---- reset in the middle of a data transfer ----
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_we_i = 1'b1;
      step();
      check("rmid_grant", grant_o, 2'b10);
      rst_i = 1'b0;
      step();
      check("rmid_rgrant", grant_o, 2'b00);
      check("rmid_cyc", wbm_cyc_o, 1'b0);
      check("rmid_stb", wbm_stb_o, 1'b0);
      check("rmid_we", wbm_we_o, 1'b0);
      rst_i = 1'b1;
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      step();
      check("rmid_first", grant_o, 2'b10);
      wbm_ack_i = 1'b1;
      #1;
      check("rmid_dack", dwb_ack_o, 1'b1);
      step();
      drop_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
